// File: rtl/multicycle_sequencer_if.sv
`default_nettype none
//==============================================================================
// multicycle_sequencer_if : control/handshake bundle between sequencer and datapath. Rev 1.0
//==============================================================================
interface multicycle_sequencer_if #(
  parameter int RET_W = 32
);
  logic [6:0]       opcode;
  logic             alu_zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             reg_write;
  logic [1:0]       mem_to_reg;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [RET_W-1:0] retired;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write,
           mem_to_reg, alu_src, alu_op, trap, trap_cause, retired
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write,
           mem_to_reg, alu_src, alu_op, trap, trap_cause, retired
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
//==============================================================================
// multicycle_sequencer : RV32I FETCH/DECODE/EXECUTE/MEM/WB control FSM. Rev 1.0
//==============================================================================
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32
) (
  input  wire logic               clk,
  input  wire logic               rst,
  multicycle_sequencer_if.master  seq_if
);

  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam int CW         = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TO_LAST_I  = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];

  typedef enum logic [2:0] {
    RST_S = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
    MEM = 3'd4, WB = 3'd5, TRAP = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE = 3'd0, CL_R = 3'd1, CL_I = 3'd2, CL_LOAD = 3'd3,
    CL_STORE = 3'd4, CL_BR = 3'd5, CL_JAL = 3'd6
  } class_t;

  // ir_en/pc_on_ready/pc_src_zero are qualified by live mem_ready/alu_zero.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_en;
    logic       pc_write;
    logic       pc_on_ready;
    logic       pc_src;
    logic       pc_src_zero;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic class_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: return CL_R;
      7'b0010011: return CL_I;
      7'b0000011: return CL_LOAD;
      7'b0100011: return CL_STORE;
      7'b1100011: return CL_BR;
      7'b1101111: return CL_JAL;
      default:    return CL_NONE;
    endcase
  endfunction

  function automatic ctrl_t decode_ctrl(input state_t s, input class_t c);
    ctrl_t k;
    k = '0;
    case (s)
      FETCH: begin
        k.mem_req = 1'b1;
        k.ir_en   = 1'b1;
      end
      EXECUTE: begin
        case (c)
          CL_R:                     k.alu_op  = 2'b10;
          CL_I, CL_LOAD, CL_STORE:  k.alu_src = 1'b1;
          CL_BR: begin
            k.alu_op      = 2'b01;
            k.pc_write    = 1'b1;
            k.pc_src_zero = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        k.mem_req     = 1'b1;
        k.addr_sel    = 1'b1;
        k.mem_we      = (c == CL_STORE);
        k.pc_on_ready = (c == CL_STORE);
      end
      WB: begin
        k.reg_write  = 1'b1;
        k.pc_write   = 1'b1;
        k.mem_to_reg = (c == CL_LOAD) ? 2'b01 : (c == CL_JAL) ? 2'b10 : 2'b00;
        k.pc_src     = (c == CL_JAL);
      end
      default: ;
    endcase
    return k;
  endfunction

  state_t           state_q, state_d;
  class_t           class_q, class_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  ctrl_t            ctrl_q;

  logic w_busy;
  logic w_timeout;

  assign w_busy    = (state_q == FETCH) || (state_q == MEM);
  assign w_timeout = TIMEOUT_EN && w_busy && !seq_if.mem_ready && (wait_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    ret_d   = ret_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    // Counter only survives while a request is stalled; any state change clears it.
    wait_d  = (w_busy && !seq_if.mem_ready) ? wait_q + CW'(1) : '0;
    case (state_q)
      RST_S: state_d = FETCH;
      FETCH: begin
        if (seq_if.mem_ready) begin
          state_d = DECODE;
        end else if (w_timeout) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end
      end
      DECODE: begin
        class_d = classify(seq_if.opcode);
        if (class_d == CL_NONE) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        case (class_q)
          CL_BR: begin
            state_d = FETCH;
            ret_d   = ret_q + RET_W'(1);
          end
          CL_LOAD, CL_STORE: state_d = MEM;
          default:           state_d = WB;
        endcase
      end
      MEM: begin
        if (seq_if.mem_ready) begin
          if (class_q == CL_STORE) begin
            state_d = FETCH;
            ret_d   = ret_q + RET_W'(1);
          end else begin
            state_d = WB;
          end
        end else if (w_timeout) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end
      end
      WB: begin
        state_d = FETCH;
        ret_d   = ret_q + RET_W'(1);
      end
      default: state_d = TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_S;
      class_q <= CL_NONE;
      wait_q  <= '0;
      ret_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
      ctrl_q  <= decode_ctrl(state_d, class_d);
    end
  end

  assign seq_if.mem_req    = ctrl_q.mem_req;
  assign seq_if.mem_we     = ctrl_q.mem_we;
  assign seq_if.addr_sel   = ctrl_q.addr_sel;
  assign seq_if.ir_write   = ctrl_q.ir_en & seq_if.mem_ready;
  assign seq_if.pc_write   = ctrl_q.pc_write | (ctrl_q.pc_on_ready & seq_if.mem_ready);
  assign seq_if.pc_src     = ctrl_q.pc_src | (ctrl_q.pc_src_zero & seq_if.alu_zero);
  assign seq_if.reg_write  = ctrl_q.reg_write;
  assign seq_if.mem_to_reg = ctrl_q.mem_to_reg;
  assign seq_if.alu_src    = ctrl_q.alu_src;
  assign seq_if.alu_op     = ctrl_q.alu_op;
  assign seq_if.trap       = trap_q;
  assign seq_if.trap_cause = cause_q;
  assign seq_if.retired    = ret_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
//==============================================================================
// tb_multicycle_sequencer : randomized self-checking bench for multicycle_sequencer. Rev 1.0
//==============================================================================
module tb_multicycle_sequencer;

  localparam int RW = 4;
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_TRAP = 5, P_RST = 6;
  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5, K_JAL = 6;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.RET_W(RW)) bus ();

  multicycle_sequencer #(.MEM_TIMEOUT(4), .RET_W(RW)) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int zsel    = -1;
  logic [RW-1:0] model_ret;
  logic [6:0] valid_ops [6] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL};

  logic [14:0] obs;
  assign obs = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write, bus.pc_write, bus.pc_src,
                bus.reg_write, bus.mem_to_reg, bus.alu_src, bus.alu_op, bus.trap, bus.trap_cause};

  function automatic int kind_of(input logic [6:0] op);
    case (op)
      OP_R:    return K_R;
      OP_I:    return K_I;
      OP_LD:   return K_LD;
      OP_ST:   return K_ST;
      OP_BR:   return K_BR;
      OP_JAL:  return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  // Expected control word for one cycle of a given phase of a given instruction kind.
  function automatic logic [14:0] exp_vec(input int ph, input int k, input logic rdy,
                                          input logic z, input logic [1:0] tc);
    logic mreq = 0, mwe = 0, asel = 0, irw = 0, pcw = 0, pcs = 0, rw = 0, asrc = 0, tr = 0;
    logic [1:0] m2r = 0, aop = 0, cause = 0;
    case (ph)
      P_FETCH: begin mreq = 1; irw = rdy; end
      P_EXEC: begin
        if (k == K_R) aop = 2'b10;
        if (k == K_I || k == K_LD || k == K_ST) asrc = 1;
        if (k == K_BR) begin aop = 2'b01; pcw = 1; pcs = z; end
      end
      P_MEM: begin
        mreq = 1; asel = 1; mwe = (k == K_ST);
        pcw = (k == K_ST) && rdy;
      end
      P_WB: begin
        rw = 1; pcw = 1; pcs = (k == K_JAL);
        m2r = (k == K_LD) ? 2'b01 : (k == K_JAL) ? 2'b10 : 2'b00;
      end
      P_TRAP: begin tr = 1; cause = tc; end
      default: ;
    endcase
    return {mreq, mwe, asel, irw, pcw, pcs, rw, m2r, asrc, aop, tr, cause};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic cycle(input int ph, input int k, input logic rdy, input logic [6:0] op,
                       input logic [1:0] tc, input string tag);
    bus.mem_ready = rdy;
    bus.opcode    = op;
    bus.alu_zero  = (zsel < 0) ? 1'($urandom) : 1'(zsel);
    @(negedge clk);
    check(tag, 32'(obs), 32'(exp_vec(ph, k, rdy, bus.alu_zero, tc)));
    check({tag, "_ret"}, 32'(bus.retired), 32'(model_ret));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_ret = '0;
    cycle(P_RST, K_ILL, 1'($urandom), 7'($urandom), 2'b00, "rst_state");
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input string tag);
    int k = kind_of(op);
    for (int i = 0; i < fw; i++) cycle(P_FETCH, k, 1'b0, 7'($urandom), 2'b00, {tag, "_fwait"});
    cycle(P_FETCH, k, 1'b1, 7'($urandom), 2'b00, {tag, "_fetch"});
    cycle(P_DECODE, k, 1'($urandom), op, 2'b00, {tag, "_decode"});
    cycle(P_EXEC, k, 1'($urandom), op, 2'b00, {tag, "_exec"});
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i < mw; i++) cycle(P_MEM, k, 1'b0, op, 2'b00, {tag, "_mwait"});
      cycle(P_MEM, k, 1'b1, op, 2'b00, {tag, "_mem"});
    end
    if (k != K_ST && k != K_BR) cycle(P_WB, k, 1'($urandom), op, 2'b00, {tag, "_wb"});
    model_ret = model_ret + 1'b1;
    check({tag, "_retired"}, 32'(bus.retired), 32'(model_ret));
  endtask

  task automatic run_trap_cycles(input int n, input logic [1:0] tc, input string tag);
    for (int i = 0; i < n; i++) cycle(P_TRAP, K_ILL, 1'($urandom), 7'($urandom), tc, tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode = '0;
    bus.alu_zero = 1'b0;
    model_ret = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr(OP_R, 0, 0, "r_type");
    run_instr(OP_LD, 0, 3, "load_wait3");
    zsel = 1; run_instr(OP_BR, 0, 0, "branch_taken");
    zsel = 0; run_instr(OP_BR, 0, 0, "branch_not_taken");
    zsel = -1;
    run_instr(OP_ST, 1, 2, "store");
    run_instr(OP_JAL, 0, 0, "jal");
    run_instr(OP_I, 3, 0, "ready_on_4th_fetch");
    run_instr(OP_ST, 0, 3, "ready_on_4th_mem");

    for (int n = 0; n < 40; n++) begin
      run_instr(valid_ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    // Illegal opcode traps after DECODE and stays trapped.
    cycle(P_FETCH, K_ILL, 1'b1, 7'($urandom), 2'b00, "ill_fetch");
    cycle(P_DECODE, K_ILL, 1'($urandom), 7'b1111111, 2'b00, "ill_decode");
    run_trap_cycles(20, 2'b01, "ill_trap");
    do_reset();
    run_instr(OP_R, 0, 0, "after_ill");

    // Fetch stalls four cycles with no ready -> memory timeout.
    for (int i = 0; i < 4; i++) cycle(P_FETCH, K_R, 1'b0, 7'($urandom), 2'b00, "fto_wait");
    run_trap_cycles(6, 2'b10, "fto_trap");
    do_reset();

    // Data access stalls to the limit.
    cycle(P_FETCH, K_LD, 1'b1, 7'($urandom), 2'b00, "mto_fetch");
    cycle(P_DECODE, K_LD, 1'($urandom), OP_LD, 2'b00, "mto_decode");
    cycle(P_EXEC, K_LD, 1'($urandom), OP_LD, 2'b00, "mto_exec");
    for (int i = 0; i < 4; i++) cycle(P_MEM, K_LD, 1'b0, OP_LD, 2'b00, "mto_wait");
    run_trap_cycles(6, 2'b10, "mto_trap");
    do_reset();

    // Reset in the middle of an instruction aborts it.
    run_instr(OP_I, 0, 0, "pre_abort");
    cycle(P_FETCH, K_JAL, 1'b1, 7'($urandom), 2'b00, "abort_fetch");
    cycle(P_DECODE, K_JAL, 1'($urandom), OP_JAL, 2'b00, "abort_decode");
    do_reset();
    run_instr(OP_JAL, 2, 0, "post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
